// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA receive-side timing recovery, lock checker and probe sampler
// Optional per-frame CRC-16-CCITT over active pixels when VGA_SYNC_CRC_EN is defined.
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iHS,
    input  logic        iVS,
    input  logic        iBLANK_n,
    input  logic [23:0] iRGB,
    input  logic [9:0]  iProbe_x,
    input  logic [9:0]  iProbe_y,
    input  logic        iErr_clr,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oPix_valid,
    output logic        oLocked,
    output logic        oErr_sticky,
    output logic [10:0] oLine_len,
    output logic [9:0]  oFrame_lines,
    output logic [15:0] oFrame_cnt,
    output logic [23:0] oProbe_rgb,
    output logic        oProbe_valid,
    output logic [15:0] oFrame_crc
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      state, state_n;
    logic        hs_q, vs_q, blank_q, clr_q;
    logic        hs_p, vs_p, blank_p;
    logic [23:0] rgb_q;
    logic [10:0] hcnt;
    logic [9:0]  vlines, alines, xcnt, ycnt;
    logic [3:0]  good, good_n, good_inc;
    logic        per_bad;

    logic        hs_fall, vs_fall, blank_fall;
    logic [11:0] line_len_now;
    logic        hper_bad, line_bad, frame_bad, timeout, err_set;
    logic [9:0]  vlines_inc, alines_inc;

    assign hs_fall      = hs_p & ~hs_q;
    assign vs_fall      = vs_p & ~vs_q;
    assign blank_fall   = blank_p & ~blank_q;
    assign line_len_now = {1'b0, hcnt} + 12'd1;
    assign hper_bad     = hs_fall && (line_len_now != 12'(H_TOTAL));
    assign line_bad     = blank_fall && (xcnt != 10'(H_ACTIVE));
    assign vlines_inc   = vlines + {9'd0, hs_fall};
    assign alines_inc   = alines + {9'd0, blank_fall};
    // The HS fall that coincides with VS fall closes the ending frame.
    assign frame_bad    = per_bad | hper_bad | (vlines_inc != 10'(V_TOTAL))
                        | (alines_inc != 10'(V_ACTIVE));
    assign timeout      = !hs_fall && (hcnt == 11'd2046);
    assign good_inc     = good + 4'd1;

    always_comb begin
        state_n = state;
        good_n  = good;
        err_set = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_n = MEASURE;
                    good_n  = 4'd0;
                end
            end
            MEASURE: begin
                if (vs_fall) begin
                    if (frame_bad) begin
                        good_n = 4'd0;
                    end else if (good_inc == 4'(LOCK_FRAMES)) begin
                        good_n  = 4'd0;
                        state_n = LOCKED;
                    end else begin
                        good_n = good_inc;
                    end
                end else if (line_bad) begin
                    good_n = 4'd0;
                end
            end
            LOCKED: begin
                if (line_bad || hper_bad || (vs_fall && frame_bad)) begin
                    err_set = 1'b1;
                    state_n = SEARCH;
                end
            end
            default: state_n = SEARCH;
        endcase
        if (timeout) begin
            state_n = SEARCH;
            good_n  = 4'd0;
            if (state == LOCKED) err_set = 1'b1;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state        <= SEARCH;
            good         <= 4'd0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            blank_q      <= 1'b0;
            clr_q        <= 1'b0;
            hs_p         <= 1'b0;
            vs_p         <= 1'b0;
            blank_p      <= 1'b0;
            rgb_q        <= 24'd0;
            hcnt         <= 11'd0;
            vlines       <= 10'd0;
            alines       <= 10'd0;
            xcnt         <= 10'd0;
            ycnt         <= 10'd0;
            per_bad      <= 1'b0;
            oX           <= 10'd0;
            oY           <= 10'd0;
            oPix_valid   <= 1'b0;
            oLocked      <= 1'b0;
            oErr_sticky  <= 1'b0;
            oLine_len    <= 11'd0;
            oFrame_lines <= 10'd0;
            oFrame_cnt   <= 16'd0;
            oProbe_rgb   <= 24'd0;
            oProbe_valid <= 1'b0;
        end else begin
            hs_q    <= iHS;
            vs_q    <= iVS;
            blank_q <= iBLANK_n;
            clr_q   <= iErr_clr;
            rgb_q   <= iRGB;
            hs_p    <= hs_q;
            vs_p    <= vs_q;
            blank_p <= blank_q;
            state   <= state_n;
            good    <= good_n;
            oLocked <= (state_n == LOCKED);
            oErr_sticky <= err_set | (oErr_sticky & ~clr_q);

            if (hs_fall) begin
                oLine_len <= line_len_now[11] ? 11'h7FF : line_len_now[10:0];
                hcnt      <= 11'd0;
            end else if (hcnt != 11'h7FF) begin
                hcnt <= hcnt + 11'd1;
            end

            if (vs_fall) begin
                oFrame_lines <= vlines_inc;
                oFrame_cnt   <= oFrame_cnt + 16'd1;
                vlines       <= 10'd0;
                alines       <= 10'd0;
                ycnt         <= 10'd0;
                per_bad      <= 1'b0;
            end else begin
                vlines  <= vlines_inc;
                alines  <= alines_inc;
                per_bad <= per_bad | hper_bad;
                if (blank_fall) ycnt <= ycnt + 10'd1;
            end

            if (blank_fall) begin
                xcnt <= 10'd0;
            end else if (blank_q && xcnt != 10'h3FF) begin
                xcnt <= xcnt + 10'd1;
            end

            oPix_valid <= blank_q;
            oX         <= blank_q ? xcnt : 10'd0;
            oY         <= ycnt;

            // Probe coordinates are compared live, not through the input registers.
            oProbe_valid <= blank_q && (xcnt == iProbe_x) && (ycnt == iProbe_y);
            if (blank_q && (xcnt == iProbe_x) && (ycnt == iProbe_y)) oProbe_rgb <= rgb_q;
        end
    end

`ifdef VGA_SYNC_CRC_EN
    logic [15:0] crc;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 23; i >= 0; i--) begin
            r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        end
        return r;
    endfunction

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            crc        <= 16'hFFFF;
            oFrame_crc <= 16'd0;
        end else if (vs_fall) begin
            oFrame_crc <= crc;
            crc        <= 16'hFFFF;
        end else if (blank_q) begin
            crc <= crc_step(crc, rgb_q);
        end
    end
`else
    assign oFrame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed self-checking bench for vga_sync_decoder
// Uses a reduced raster (16x6 active, 24x10 total) to keep runs short.
module tb_vga_sync_decoder;

    localparam int HA = 16, VA = 6, HT = 24, VT = 10;
    localparam int HS_W = 2, H_BP = 4, V_SW = 2, V_AS = 3;

    logic        iVGA_CLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic        iHS = 1'b1, iVS = 1'b1, iBLANK_n = 1'b0, iErr_clr = 1'b0;
    logic [23:0] iRGB = 24'd0;
    logic [9:0]  iProbe_x = 10'd0, iProbe_y = 10'd0;
    logic [9:0]  oX, oY, oFrame_lines;
    logic        oPix_valid, oLocked, oErr_sticky, oProbe_valid;
    logic [10:0] oLine_len;
    logic [15:0] oFrame_cnt, oFrame_crc;
    logic [23:0] oProbe_rgb;

    int checks = 0, failures = 0;
    int probe_hits, pix_cnt, xsum, ysum;
    logic [23:0] probe_last;
    logic rgb_zero = 1'b0;

    vga_sync_decoder #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(2)) dut (
        .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iHS(iHS), .iVS(iVS), .iBLANK_n(iBLANK_n),
        .iRGB(iRGB), .iProbe_x(iProbe_x), .iProbe_y(iProbe_y), .iErr_clr(iErr_clr),
        .oX(oX), .oY(oY), .oPix_valid(oPix_valid), .oLocked(oLocked), .oErr_sticky(oErr_sticky),
        .oLine_len(oLine_len), .oFrame_lines(oFrame_lines), .oFrame_cnt(oFrame_cnt),
        .oProbe_rgb(oProbe_rgb), .oProbe_valid(oProbe_valid), .oFrame_crc(oFrame_crc)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    // Observe outputs on the falling edge, then drive the next input sample.
    task automatic tick(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
        @(negedge iVGA_CLK);
        if (oProbe_valid) begin
            probe_hits++;
            probe_last = oProbe_rgb;
        end
        if (oPix_valid) begin
            pix_cnt++;
            xsum += int'(oX);
            ysum += int'(oY);
        end
        iHS = hs; iVS = vs; iBLANK_n = bl; iRGB = rgb;
    endtask

    task automatic drive_line(input int line, input int nclk);
        for (int c = 0; c < nclk; c++) begin
            logic act;
            logic [23:0] rgb;
            act = (line >= V_AS) && (line < V_AS + VA) && (c >= H_BP) && (c < H_BP + HA);
            rgb = (act && !rgb_zero) ? {4'h0, 10'(c - H_BP), 10'(line - V_AS)} : 24'd0;
            tick(!(c < HS_W), !(line < V_SW), act, rgb);
        end
    endtask

    task automatic drive_frame();
        for (int l = 0; l < VT; l++) drive_line(l, HT);
    endtask

    function automatic logic [15:0] model_crc_zero(input int npix);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int p = 0; p < npix * 24; p++) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        return c;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 24'd0);
        checks++; if (oLocked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", oLocked); end
        checks++; if (oErr_sticky !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%0b exp=0", oErr_sticky); end
        checks++; if (oLine_len !== 11'd0) begin failures++; $display("FAIL reset_line_len got=%0d exp=0", oLine_len); end
        checks++; if (oFrame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", oFrame_cnt); end
        checks++; if (oFrame_crc !== 16'd0) begin failures++; $display("FAIL reset_crc got=%0h exp=0", oFrame_crc); end
        @(negedge iVGA_CLK);
        iRST_n = 1'b1;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 24'd0);
    endtask

    task automatic test_lock();
        drive_frame();
        drive_frame();
        checks++; if (oLocked !== 1'b0) begin failures++; $display("FAIL lock_early got=%0b exp=0", oLocked); end
        drive_frame();
        checks++; if (oLocked !== 1'b1) begin failures++; $display("FAIL lock_rise got=%0b exp=1", oLocked); end
        checks++; if (oLine_len !== 11'd24) begin failures++; $display("FAIL lock_line_len got=%0d exp=24", oLine_len); end
        checks++; if (oFrame_lines !== 10'd10) begin failures++; $display("FAIL lock_frame_lines got=%0d exp=10", oFrame_lines); end
        checks++; if (oErr_sticky !== 1'b0) begin failures++; $display("FAIL lock_sticky got=%0b exp=0", oErr_sticky); end
        checks++; if (oFrame_cnt !== 16'd3) begin failures++; $display("FAIL lock_frame_cnt got=%0d exp=3", oFrame_cnt); end
    endtask

    task automatic test_pixels();
        pix_cnt = 0; xsum = 0; ysum = 0;
        drive_frame();
        checks++; if (pix_cnt != 96) begin failures++; $display("FAIL pix_count got=%0d exp=96", pix_cnt); end
        checks++; if (xsum != 720) begin failures++; $display("FAIL pix_xsum got=%0d exp=720", xsum); end
        checks++; if (ysum != 240) begin failures++; $display("FAIL pix_ysum got=%0d exp=240", ysum); end
    endtask

    task automatic test_probe();
        iProbe_x = 10'd15; iProbe_y = 10'd5; probe_hits = 0; probe_last = 24'd0;
        drive_frame();
        drive_frame();
        checks++; if (probe_hits != 2) begin failures++; $display("FAIL probe_corner_hits got=%0d exp=2", probe_hits); end
        checks++; if (probe_last !== {4'h0, 10'd15, 10'd5}) begin failures++; $display("FAIL probe_corner_rgb got=%0h exp=%0h", probe_last, {4'h0, 10'd15, 10'd5}); end
        iProbe_x = 10'd16; iProbe_y = 10'd0; probe_hits = 0;
        drive_frame();
        checks++; if (probe_hits != 0) begin failures++; $display("FAIL probe_outside_hits got=%0d exp=0", probe_hits); end
        iProbe_x = 10'd3; iProbe_y = 10'd2; probe_hits = 0;
        drive_frame();
        checks++; if (probe_hits != 1) begin failures++; $display("FAIL probe_mid_hits got=%0d exp=1", probe_hits); end
        checks++; if (probe_last !== {4'h0, 10'd3, 10'd2}) begin failures++; $display("FAIL probe_mid_rgb got=%0h exp=%0h", probe_last, {4'h0, 10'd3, 10'd2}); end
    endtask

    task automatic test_short_line();
        for (int l = 0; l < 5; l++) drive_line(l, HT);
        drive_line(5, HT - 1);
        drive_line(6, HT);
        checks++; if (oErr_sticky !== 1'b1) begin failures++; $display("FAIL short_sticky got=%0b exp=1", oErr_sticky); end
        checks++; if (oLocked !== 1'b0) begin failures++; $display("FAIL short_unlock got=%0b exp=0", oLocked); end
        checks++; if (oLine_len !== 11'd23) begin failures++; $display("FAIL short_line_len got=%0d exp=23", oLine_len); end
        for (int l = 7; l < VT; l++) drive_line(l, HT);
        drive_frame();
        drive_frame();
        checks++; if (oLocked !== 1'b0) begin failures++; $display("FAIL short_relock_early got=%0b exp=0", oLocked); end
        drive_frame();
        checks++; if (oLocked !== 1'b1) begin failures++; $display("FAIL short_relock got=%0b exp=1", oLocked); end
        checks++; if (oErr_sticky !== 1'b1) begin failures++; $display("FAIL short_sticky_held got=%0b exp=1", oErr_sticky); end
        iErr_clr = 1'b1;
        drive_frame();
        iErr_clr = 1'b0;
        checks++; if (oErr_sticky !== 1'b0) begin failures++; $display("FAIL clr_sticky got=%0b exp=0", oErr_sticky); end
        checks++; if (oLocked !== 1'b1) begin failures++; $display("FAIL clr_locked got=%0b exp=1", oLocked); end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 2000; i++) tick(1'b1, 1'b1, 1'b0, 24'd0);
        checks++; if (oLocked !== 1'b1) begin failures++; $display("FAIL timeout_early_lock got=%0b exp=1", oLocked); end
        checks++; if (oErr_sticky !== 1'b0) begin failures++; $display("FAIL timeout_early_sticky got=%0b exp=0", oErr_sticky); end
        for (int i = 0; i < 1000; i++) tick(1'b1, 1'b1, 1'b0, 24'd0);
        checks++; if (oLocked !== 1'b0) begin failures++; $display("FAIL timeout_lock got=%0b exp=0", oLocked); end
        checks++; if (oErr_sticky !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%0b exp=1", oErr_sticky); end
        checks++; if (oLine_len !== 11'd24) begin failures++; $display("FAIL timeout_line_len got=%0d exp=24", oLine_len); end
    endtask

    task automatic test_reset_mid();
        drive_frame();
        drive_frame();
        drive_frame();
        checks++; if (oLocked !== 1'b1) begin failures++; $display("FAIL mid_prelock got=%0b exp=1", oLocked); end
        for (int l = 0; l < 4; l++) drive_line(l, HT);
        drive_line(4, 10);
        checks++; if (oPix_valid !== 1'b1) begin failures++; $display("FAIL mid_pix_valid got=%0b exp=1", oPix_valid); end
        checks++; if (oY !== 10'd1) begin failures++; $display("FAIL mid_y got=%0d exp=1", oY); end
        #1 iRST_n = 1'b0;
        #1;
        checks++; if (oPix_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_pix got=%0b exp=0", oPix_valid); end
        checks++; if (oLocked !== 1'b0 || oErr_sticky !== 1'b0) begin failures++; $display("FAIL mid_rst_status got=%0b%0b exp=00", oLocked, oErr_sticky); end
        checks++; if (oX !== 10'd0 || oY !== 10'd0) begin failures++; $display("FAIL mid_rst_xy got=%0d,%0d exp=0,0", oX, oY); end
        checks++; if (oFrame_cnt !== 16'd0 || oLine_len !== 11'd0 || oFrame_lines !== 10'd0) begin failures++; $display("FAIL mid_rst_counts got=%0d,%0d,%0d exp=0,0,0", oFrame_cnt, oLine_len, oFrame_lines); end
        checks++; if (oProbe_rgb !== 24'd0) begin failures++; $display("FAIL mid_rst_probe got=%0h exp=0", oProbe_rgb); end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 24'd0);
        iRST_n = 1'b1;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 24'd0);
        drive_frame();
        drive_frame();
        checks++; if (oLocked !== 1'b0) begin failures++; $display("FAIL mid_relock_early got=%0b exp=0", oLocked); end
        drive_frame();
        checks++; if (oLocked !== 1'b1) begin failures++; $display("FAIL mid_relock got=%0b exp=1", oLocked); end
    endtask

    task automatic test_crc();
        logic [15:0] exp_crc;
`ifdef VGA_SYNC_CRC_EN
        exp_crc = model_crc_zero(HA * VA);
`else
        exp_crc = 16'h0000;
`endif
        rgb_zero = 1'b1;
        drive_frame();
        rgb_zero = 1'b0;
        drive_frame();
        checks++; if (oFrame_crc !== exp_crc) begin failures++; $display("FAIL crc_zero_frame got=%0h exp=%0h", oFrame_crc, exp_crc); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_pixels();
        test_probe();
        test_short_line();
        test_timeout();
        test_reset_mid();
        test_crc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
